// File: rtl/shift_stream_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : shift_stream_pkg                                             |
// | Description : Shared types and constants for the pipelined shift stage.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package shift_stream_pkg;

  // Shift operation select carried alongside each operand.
  typedef enum logic [1:0] {
    SHIFT_LSL = 2'b00,  // logical left, zero fill
    SHIFT_LSR = 2'b01,  // logical right, zero fill
    SHIFT_ASR = 2'b10,  // arithmetic right, sign fill
    SHIFT_ROL = 2'b11   // rotate left
  } shift_mode_e;

  // Width of the completed-operation counter.
  localparam int OPCNT_W = 16;

endpackage : shift_stream_pkg

`default_nettype wire

// File: rtl/shift_core.sv
// +----------------------------------------------------------------------------+
// | Module      : shift_core                                                   |
// | Description : Combinational barrel shifter built from log2(WIDTH) mux      |
// |               stages; stage k shifts by 2**k when amt[k] is set.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module shift_core
  import shift_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] amt,
  input  shift_mode_e      mode,
  output logic [WIDTH-1:0] result
);

  // w_stage[0] is the operand, w_stage[AMT_W] the fully shifted word.
  logic [AMT_W:0][WIDTH-1:0] w_stage;

  assign w_stage[0] = data;

  generate
    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
      localparam int SH = 1 << k;

      logic [WIDTH-1:0] w_cur;
      logic [WIDTH-1:0] w_shifted;

      assign w_cur = w_stage[k];

      // Shift by this stage's fixed power-of-two distance. For ASR the MSB
      // is preserved through every stage, so the fill always equals the
      // original operand's sign bit.
      always_comb begin
        w_shifted = w_cur;
        case (mode)
          SHIFT_LSL: w_shifted = w_cur << SH;
          SHIFT_LSR: w_shifted = w_cur >> SH;
          SHIFT_ASR: w_shifted = $unsigned($signed(w_cur) >>> SH);
          SHIFT_ROL: w_shifted = (w_cur << SH) | (w_cur >> (WIDTH - SH));
          default:   w_shifted = w_cur;
        endcase
      end

      assign w_stage[k+1] = amt[k] ? w_shifted : w_cur;
    end
  endgenerate

  assign result = w_stage[AMT_W];

endmodule : shift_core

`default_nettype wire

// File: rtl/shift_stream_stage.sv
// +----------------------------------------------------------------------------+
// | Module      : shift_stream_stage                                           |
// | Description : Two-stage valid/ready shift pipeline. S1 holds the accepted  |
// |               operand, S2 holds the registered result. Counts completed   |
// |               output handshakes.                                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module shift_stream_stage
  import shift_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [AMT_W-1:0]   in_amt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_zero,
  output logic [OPCNT_W-1:0] op_count,
  output logic               busy
);

  // Stage 1: accepted operand
  logic               r_s1_valid;
  logic [WIDTH-1:0]   r_s1_data;
  logic [AMT_W-1:0]   r_s1_amt;
  shift_mode_e        r_s1_mode;

  // Stage 2: registered result
  logic               r_s2_valid;
  logic [WIDTH-1:0]   r_s2_data;
  logic               r_s2_zero;

  logic [OPCNT_W-1:0] r_op_count;

  logic               w_s2_load;
  logic               w_s1_load;
  logic               w_in_hs;
  logic               w_out_hs;
  logic [WIDTH-1:0]   w_result;

  // S2 can take a new value when it is empty or its content leaves this
  // cycle. S1 can take a new operand when it is empty or when S2 loads; an
  // S2 load always drains a full S1, so the "S2 loads from S1" qualifier
  // reduces to w_s2_load. in_valid never participates, keeping in_ready
  // free of a combinational path from the producer.
  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign w_in_hs   = in_valid && w_s1_load;
  assign w_out_hs  = r_s2_valid && out_ready;

  shift_core #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_core (
    .data   (r_s1_data),
    .amt    (r_s1_amt),
    .mode   (r_s1_mode),
    .result (w_result)
  );

  // S1: capture the operand on an input handshake, otherwise empty once drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_amt   <= '0;
      r_s1_mode  <= SHIFT_LSL;
    end else if (w_in_hs) begin
      r_s1_valid <= 1'b1;
      r_s1_data  <= in_data;
      r_s1_amt   <= in_amt;
      r_s1_mode  <= shift_mode_e'(in_mode);
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  // S2: take the shifted word when it may load; payload holds otherwise so
  // out_data/out_zero stay stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_zero  <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_result;
        r_s2_zero <= (w_result == '0);
      end
    end
  end

  // Count completed output handshakes, wrapping naturally at the counter width.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_out_hs) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

  assign in_ready  = w_s1_load;
  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign out_zero  = r_s2_zero;
  assign op_count  = r_op_count;
  assign busy      = r_s1_valid || r_s2_valid;

endmodule : shift_stream_stage

`default_nettype wire

// File: tb/tb_shift_stream_stage.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_shift_stream_stage                                        |
// | Description : Self-checking bench for shift_stream_stage with a queue-    |
// |               based reference model and directed plus random stimulus.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_shift_stream_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic [2:0]  in_amt = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_zero;
  logic [15:0] op_count;
  logic        busy;

  shift_stream_stage #(.WIDTH(8), .AMT_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero),
    .op_count(op_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference shift: each result bit picked directly from the operand.
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int a, input int m);
    logic [7:0] r;
    int j;
    for (int i = 0; i < 8; i++) begin
      case (m)
        0: begin j = i - a; r[i] = (j >= 0) ? d[j] : 1'b0; end
        1: begin j = i + a; r[i] = (j < 8) ? d[j] : 1'b0; end
        2: begin j = i + a; r[i] = (j < 8) ? d[j] : d[7]; end
        default: begin j = (i - a + 8) % 8; r[i] = d[j]; end
      endcase
    end
    return r;
  endfunction

  // Model state: entries accepted but not yet delivered, oldest first.
  typedef struct { logic [7:0] res; int acc; } ent_t;
  ent_t        q[$];
  logic [15:0] mcount = '0;
  int          edge_cnt = 0;
  logic [7:0]  outlog[$];
  logic        zlog[$];
  logic        exp_ov;
  logic        exp_rdy;

  always @(posedge clk) edge_cnt++;

  // Compare process: DUT outputs against the model every cycle, then apply
  // the handshakes that the coming edge performs.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mcount = '0;
    end else begin
      // The oldest entry is presented from the second edge after acceptance;
      // input is blocked only with two entries held and the output stalled.
      exp_ov  = (q.size() > 0) ? (edge_cnt > q[0].acc) : 1'b0;
      exp_rdy = !(q.size() == 2 && !out_ready);
      chk("in_ready", in_ready, exp_rdy);
      chk("out_valid", out_valid, exp_ov);
      chk("busy", busy, q.size() != 0);
      chk("op_count", op_count, mcount);
      if (exp_ov) begin
        chk("out_data", out_data, q[0].res);
        chk("out_zero", out_zero, q[0].res == 8'h00);
      end
      if (exp_ov && out_ready) begin
        outlog.push_back(out_data);
        zlog.push_back(out_zero);
        void'(q.pop_front());
        mcount = mcount + 16'd1;
      end
      if (in_valid && exp_rdy)
        q.push_back('{ref_shift(in_data, int'(in_amt), int'(in_mode)), edge_cnt + 1});
    end
  end

  // All driver tasks start and end just after a rising edge.
  task automatic reset_dut();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m);
    bit done = 0;
    in_valid = 1'b1; in_data = d; in_amt = a; in_mode = m;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    if (!done) chk("push_timeout", 1, 0);
  endtask

  // Stops the input and waits (bounded) for the pipe to empty; returns at a falling edge.
  task automatic wait_drain();
    bit ok = 0;
    in_valid = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1;
    end
    if (!ok) chk("drain_timeout", 1, 0);
  endtask

  task automatic realign();
    @(posedge clk); #1;
  endtask

  logic [7:0]  exp_a[4];
  logic [15:0] exp_w[3];
  int          t0;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset_dut();

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_zero", out_zero, 0);
    realign();

    // One word per mode, amount 3
    out_ready = 1'b1;
    outlog.delete(); zlog.delete();
    for (int m = 0; m < 4; m++) push(8'b10110011, 3'd3, 2'(m));
    wait_drain();
    exp_a[0] = 8'b10011000; exp_a[1] = 8'b00010110;
    exp_a[2] = 8'b11110110; exp_a[3] = 8'b10011101;
    chk("modes_count", outlog.size(), 4);
    for (int i = 0; i < 4 && i < outlog.size(); i++) chk("modes_data", outlog[i], exp_a[i]);
    chk("modes_op_count", op_count, 4);
    realign();

    // Amount 0 returns the operand in every mode
    outlog.delete(); zlog.delete();
    for (int m = 0; m < 4; m++) push(8'b11110000, 3'd0, 2'(m));
    wait_drain();
    chk("amt0_count", outlog.size(), 4);
    for (int i = 0; i < outlog.size(); i++) begin
      chk("amt0_data", outlog[i], 8'b11110000);
      chk("amt0_zero", zlog[i], 0);
    end
    realign();

    // Zero result
    outlog.delete(); zlog.delete();
    push(8'b00000001, 3'd1, 2'b01);
    wait_drain();
    chk("zero_count", outlog.size(), 1);
    if (outlog.size() > 0) begin
      chk("zero_data", outlog[0], 8'h00);
      chk("zero_flag", zlog[0], 1);
    end
    realign();

    // Backpressure: A, B fill the pipe, C waits
    reset_dut();
    outlog.delete(); zlog.delete();
    out_ready = 1'b0;
    push(8'h01, 3'd1, 2'b00);   // A -> 02
    push(8'h80, 3'd7, 2'b01);   // B -> 01
    in_valid = 1'b1; in_data = 8'h81; in_amt = 3'd1; in_mode = 2'b11;  // C -> 03
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_data_hold", out_data, 8'h02);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_release", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    realign();
    realign();
    @(negedge clk);
    exp_a[0] = 8'h02; exp_a[1] = 8'h01; exp_a[2] = 8'h03;
    chk("bp_count", outlog.size(), 3);
    for (int i = 0; i < 3 && i < outlog.size(); i++) chk("bp_order", outlog[i], exp_a[i]);
    chk("bp_op_count", op_count, 3);
    chk("bp_busy", busy, 0);
    realign();

    // Full-rate stream of 20 words
    reset_dut();
    t0 = edge_cnt;
    for (int i = 0; i < 20; i++) push(8'($urandom), 3'($urandom), 2'($urandom));
    chk("stream_cycles", edge_cnt - t0, 20);
    wait_drain();
    chk("stream_op_count", op_count, 20);
    realign();

    // Mid-operation reset with two words in flight
    out_ready = 1'b0;
    push(8'h55, 3'd2, 2'b00);
    push(8'hAA, 3'd2, 2'b10);
    outlog.delete(); zlog.delete();
    out_ready = 1'b1;
    reset_dut();
    @(negedge clk);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_op_count", op_count, 0);
    realign();
    realign();
    @(negedge clk);
    chk("mrst_no_output", outlog.size(), 0);
    chk("mrst_op_count_after", op_count, 0);
    realign();

    // Randomized traffic with random backpressure
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      in_amt    = 3'($urandom);
      in_mode   = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_drain();
    realign();

    // Counter wrap
    reset_dut();
    out_ready = 1'b1;
    for (int i = 0; i < 65534; i++) push(8'($urandom), 3'($urandom), 2'($urandom));
    wait_drain();
    chk("wrap_preload", op_count, 16'hFFFE);
    realign();
    exp_w[0] = 16'hFFFF; exp_w[1] = 16'h0000; exp_w[2] = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      push(8'h3C, 3'($urandom), 2'($urandom));
      wait_drain();
      chk("wrap_step", op_count, exp_w[i]);
      realign();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule : tb_shift_stream_stage

`default_nettype wire
